// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: issues one MUL/DIV to the multi-cycle unit, stalls the
// front of the pipe while it runs, and returns a single writeback packet.
// Ports:
//   clock, reset                  rising-edge clock, async active-high reset
//   is_mult, is_div, flush        X-stage op decode and branch squash
//   operand_a, operand_b, rd_in   X-stage operands and destination register
//   data_resultRDY/exception/result  handshake coming back from the unit
//   ctrl_MULT, ctrl_DIV           one-cycle start pulses to the unit
//   md_a, md_b                    latched operands to the unit
//   stall                         freezes PC, F/D and D/X
//   result_valid, result, result_rd, exception  writeback packet
module multdiv_sequencer #(
    parameter int          MAX_CYCLES = 40,
    parameter logic [31:0] EXC_MULT   = 32'd4,
    parameter logic [31:0] EXC_DIV    = 32'd5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        is_mult,
    input  logic        is_div,
    input  logic        flush,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    input  logic        data_resultRDY,
    input  logic        data_exception,
    input  logic [31:0] data_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  result_rd,
    output logic        exception
);

    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          op_mult;
    logic [4:0]    rd_q;
    logic [CW-1:0] count;
    logic          accept;
    logic          timeout;
    logic          capture;
    logic          exc_pkt;

    assign accept  = (state == IDLE) & (is_mult | is_div) & ~flush;
    assign timeout = (count == CW'(MAX_CYCLES - 1));
    // A flush in BUSY wins over a same-cycle result: the op is squashed.
    assign capture = (state == BUSY) & ~flush & (data_resultRDY | timeout);
    // No resultRDY at capture time means the cycle budget ran out.
    assign exc_pkt = ~data_resultRDY | data_exception;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        result_valid = 1'b0;
        unique case (state)
            IDLE: begin
                stall = accept;
                if (accept) state_nxt = START;
            end
            START: begin
                ctrl_MULT = op_mult;
                ctrl_DIV  = ~op_mult;
                // Stall releases in the flush cycle so the branch target
                // can be fetched without a bubble.
                stall     = ~flush;
                state_nxt = flush ? IDLE : BUSY;
            end
            BUSY: begin
                stall = ~flush;
                if (flush)        state_nxt = IDLE;
                else if (capture) state_nxt = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_a      <= '0;
            md_b      <= '0;
            rd_q      <= '0;
            op_mult   <= 1'b0;
            count     <= '0;
            result    <= '0;
            result_rd <= '0;
            exception <= 1'b0;
        end else begin
            if (accept) begin
                md_a    <= operand_a;
                md_b    <= operand_b;
                rd_q    <= rd_in;
                op_mult <= is_mult;
            end
            if (state == START) count <= '0;
            else if (state == BUSY) count <= count + 1'b1;
            if (capture) begin
                exception <= exc_pkt;
                if (exc_pkt) begin
                    result    <= op_mult ? EXC_MULT : EXC_DIV;
                    result_rd <= 5'd30;
                end else begin
                    result    <= data_result;
                    result_rd <= rd_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed stimulus with a packet scoreboard for
// multdiv_sequencer; a negedge monitor checks every writeback packet.
`timescale 1ns/1ps
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        is_mult, is_div, flush;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd_in;
    logic        data_resultRDY, data_exception;
    logic [31:0] data_result;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] md_a, md_b;
    logic        stall, result_valid;
    logic [31:0] result;
    logic [4:0]  result_rd;
    logic        exception;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        exc;
    } pkt_t;

    pkt_t q[$];
    int   checks = 0;
    int   errors = 0;

    multdiv_sequencer dut (
        .clock(clock), .reset(reset),
        .is_mult(is_mult), .is_div(is_div), .flush(flush),
        .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
        .data_resultRDY(data_resultRDY), .data_exception(data_exception),
        .data_result(data_result),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .md_a(md_a), .md_b(md_b), .stall(stall),
        .result_valid(result_valid), .result(result),
        .result_rd(result_rd), .exception(exception)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected packet per result_valid.
    always @(negedge clock) begin
        if (!reset && result_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result %0h rd %0d, expected none",
                         result, result_rd);
            end else begin
                pkt_t e;
                e = q.pop_front();
                chk("pkt_result", result, e.res);
                chk("pkt_rd", 32'(result_rd), 32'(e.rd));
                chk("pkt_exc", 32'(exception), 32'(e.exc));
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            is_mult = 0; is_div = 0; flush = 0;
            data_resultRDY = 0; data_exception = 0;
            @(negedge clock);
            chk("idle_stall", 32'(stall), 32'd0);
        end
    endtask

    // Cycle 0 = acceptance, 1 = START. rdy_cyc=0: unit never answers.
    // flush_cyc=0: no flush. done_cyc is the expected DONE cycle.
    task automatic run_op(
        input logic m, input logic d,
        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
        input int rdy_cyc, input logic exc, input logic [31:0] res,
        input int flush_cyc, input int done_cyc,
        input logic [31:0] e_res, input logic [4:0] e_rd, input logic e_exc);
        pkt_t p;
        logic found;
        found = 1'b0;
        @(posedge clock); #1;
        is_mult = m; is_div = d; flush = 0;
        operand_a = a; operand_b = b; rd_in = rd;
        data_resultRDY = 0; data_exception = 0;
        @(negedge clock);
        chk("accept_stall", 32'(stall), 32'd1);
        if (flush_cyc == 0) begin
            p.res = e_res; p.rd = e_rd; p.exc = e_exc;
            q.push_back(p);
        end
        @(posedge clock); #1;
        operand_a = 32'hffff_ffff; operand_b = 32'hffff_ffff; rd_in = 5'd31;
        @(negedge clock);
        chk("start_ctrl_mult", 32'(ctrl_MULT), 32'(m));
        chk("start_ctrl_div", 32'(ctrl_DIV), 32'(d & ~m));
        chk("start_stall", 32'(stall), 32'd1);
        chk("md_a", md_a, a);
        chk("md_b", md_b, b);
        for (int c = 2; c < 100; c++) begin
            @(posedge clock); #1;
            data_resultRDY = (c == rdy_cyc);
            data_exception = (c == rdy_cyc) & exc;
            data_result    = (c == rdy_cyc) ? res : 32'h0bad_f00d;
            flush          = (c == flush_cyc);
            @(negedge clock);
            if (flush_cyc != 0 && c == flush_cyc) begin
                chk("flush_stall", 32'(stall), 32'd0);
                chk("flush_no_valid", 32'(result_valid), 32'd0);
                found = 1'b1;
                break;
            end else if (result_valid) begin
                chk("done_cycle", 32'(c), 32'(done_cyc));
                chk("done_stall", 32'(stall), 32'd0);
                found = 1'b1;
                break;
            end else begin
                chk("busy_stall", 32'(stall), 32'd1);
                if (c == 2) chk("busy_ctrl",
                                32'({ctrl_MULT, ctrl_DIV}), 32'd0);
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: got no DONE/flush, expected by cycle 99");
        end
        if (flush_cyc != 0) begin
            for (int k = 1; k <= 8; k++) begin
                @(posedge clock); #1;
                is_mult = 0; is_div = 0; flush = 0;
                data_resultRDY = (k == 4);
                data_result = 32'h1234;
                @(negedge clock);
                chk("post_flush_stall", 32'(stall), 32'd0);
                chk("post_flush_valid", 32'(result_valid), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end by 200us");
        $fatal(1);
    end

    initial begin
        reset = 1; is_mult = 0; is_div = 0; flush = 0;
        operand_a = 0; operand_b = 0; rd_in = 0;
        data_resultRDY = 0; data_exception = 0; data_result = 0;
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", 32'(result_rd), 32'd0);
        chk("rst_exc", 32'(exception), 32'd0);
        chk("rst_md_a", md_a, 32'd0);
        @(posedge clock); @(posedge clock); #1;
        reset = 0;
        idle(2);

        // MUL 6*7 -> 42, RDY 16 cycles after START
        run_op(1, 0, 6, 7, 3, 17, 0, 42, 0, 18, 42, 3, 0);
        idle(2);
        // DIV 9/0 -> divide exception
        run_op(0, 1, 9, 0, 7, 34, 1, 32'hdead, 0, 35, 5, 30, 1);
        idle(2);
        // MUL with no answer -> timeout at cycle 42
        run_op(1, 0, 32'h10000, 32'h10000, 11, 0, 0, 0, 0, 42, 4, 30, 1);
        idle(2);
        // DIV flushed in BUSY cycle 5, late RDY ignored
        run_op(0, 1, 20, 4, 8, 0, 0, 0, 5, 0, 0, 0, 0);
        idle(2);
        // back-to-back MUL then DIV
        run_op(1, 0, 3, 5, 9, 3, 0, 15, 0, 4, 15, 9, 0);
        run_op(0, 1, 100, 7, 12, 6, 0, 14, 0, 7, 14, 12, 0);
        idle(2);
        // is_mult & is_div together: MUL code on exception
        run_op(1, 1, 2, 3, 5, 10, 1, 0, 0, 11, 4, 30, 1);
        idle(2);

        // flush in IDLE blocks acceptance
        @(posedge clock); #1;
        is_mult = 1; flush = 1;
        @(negedge clock);
        chk("idle_flush_stall", 32'(stall), 32'd0);
        @(posedge clock); #1;
        is_mult = 0; flush = 0;
        @(negedge clock);
        chk("idle_flush_not_accepted", 32'(stall), 32'd0);

        // async reset while BUSY
        @(posedge clock); #1;
        is_div = 1; operand_a = 50; operand_b = 2; rd_in = 4;
        repeat (3) @(posedge clock);
        #2;
        reset = 1; is_div = 0;
        #1;
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
        chk("arst_md_a", md_a, 32'd0);
        chk("arst_md_b", md_b, 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_exc", 32'(exception), 32'd0);
        @(posedge clock); #1;
        reset = 0;
        @(posedge clock); #1;
        data_resultRDY = 1;
        @(negedge clock);
        chk("arst_after_stall", 32'(stall), 32'd0);
        idle(4);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
